mux_stream: RTL

Parametrised N-way, W-bit selector with valid/ready handshakes on every input and a registered output stage. It generalises the 2-bit, 32-input combinational selector to any channel count and width, and adds two things that selector lacks: backpressure and an optional round-robin arbitration mode. It sits between parallel producer channels and a single downstream consumer. Exactly one beat moves per cycle at full throughput.

---
 rtl/mux_stream_pkg.sv | 19 +
 rtl/mux_stream_if.sv | 28 ++
 rtl/mux_stream_rr_picker.sv | 31 +++
 rtl/mux_stream.sv | 110 +++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// rtl/mux_stream_pkg.sv - shared types, width helper and reset constants for mux_stream
package mux_stream_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Keeps index fields at least one bit wide even for degenerate channel counts
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam state_e RST_STATE   = ST_EMPTY;
  localparam logic   RST_ERR_SEL = 1'b0;
  localparam int     RST_DATA    = 0;
  localparam int     RST_IDX     = 0;

endpackage

// File: rtl/mux_stream_if.sv
// rtl/mux_stream_if.sv - producer-side channels and consumer-side output of mux_stream
interface mux_stream_if
  import mux_stream_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 2,
  localparam int SEL_W   = clog2_safe(N_INPUTS)
) ();

  logic [N_INPUTS*DATA_W-1:0] in_data;
  logic [N_INPUTS-1:0]        in_valid;
  logic [N_INPUTS-1:0]        in_ready;
  logic [DATA_W-1:0]          out_data;
  logic [SEL_W-1:0]           out_ch;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_stream_rr_picker.sv
// rtl/mux_stream_rr_picker.sv - combinational rotate-priority encoder: first set req at or after ptr
module rr_picker
  import mux_stream_pkg::*;
#(
  parameter int N_INPUTS = 32,
  localparam int SEL_W   = clog2_safe(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  int idx;

  // Scan from the farthest offset down so the channel nearest ptr overwrites last
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      if (req[idx]) begin
        gnt_idx = SEL_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_stream.sv
// rtl/mux_stream.sv - N-way valid/ready selector with one registered output beat.
// MUX_STREAM_RR_EN adds the rr_mode port, round-robin picker and rotation pointer.
module mux_stream
  import mux_stream_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 2,
  localparam int SEL_W   = clog2_safe(N_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
`ifdef MUX_STREAM_RR_EN
  input  logic             rr_mode,
`endif
  mux_stream_if.slave      bus,
  output logic             err_sel
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d, pick_data;
  logic [SEL_W-1:0]    ch_q, ch_d, chan;
  logic                err_q, err_d;
  logic                load_en, chan_ok, fixed_mode, sel_in_range, xfer;
  logic [N_INPUTS-1:0] ready_vec;

  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(N_INPUTS));

`ifdef MUX_STREAM_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic             gnt_any;

  rr_picker #(.N_INPUTS(N_INPUTS)) u_picker (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign fixed_mode = !rr_mode;
  assign chan       = rr_mode ? gnt_idx : sel;
  assign chan_ok    = rr_mode ? gnt_any : sel_in_range;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (chan == SEL_W'(N_INPUTS - 1)) ? '0 : chan + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= SEL_W'(RST_IDX);
    else     ptr_q <= ptr_d;
  end
`else
  assign fixed_mode = 1'b1;
  assign chan       = sel;
  assign chan_ok    = sel_in_range;
`endif

  assign load_en = (state_q == ST_EMPTY) || bus.out_ready;

  // One-hot ready and payload mux; in_data reaches only the output register
  always_comb begin
    ready_vec = '0;
    pick_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (chan == SEL_W'(i)) begin
        ready_vec[i] = !rst && chan_ok && load_en;
        pick_data    = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.in_ready = ready_vec;
  assign xfer         = |(ready_vec & bus.in_valid);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = pick_data;
      ch_d    = chan;
    end else if (bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  assign err_d = fixed_mode && !sel_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      data_q  <= DATA_W'(RST_DATA);
      ch_q    <= SEL_W'(RST_IDX);
      err_q   <= RST_ERR_SEL;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign err_sel       = err_q;

endmodule
